regfile_nrmw: RTL
=================

Name: regfile_nrmw

Overview:
Parametrised multi-port register file: NUM_RD combinational read ports and NUM_WR synchronous write ports, with optional write-to-read bypass and optional hardwired zero register. Adds a per-register pending scoreboard and a hardware clear sequencer that zeroes the array after reset. Sits in the core's decode/issue stage as the architectural integer register file.

Parameters:
DATA_WIDTH, 32, bits per register
REG_FILE_SIZE, 32, number of registers; AW = $clog2(REG_FILE_SIZE)
NUM_RD, 4, read ports (>=1)
NUM_WR, 2, write ports (>=1)
ZERO_REG, 1, 1: register 0 reads 0, writes and reserves to it dropped
BYPASS, 1, 1: same-cycle write data forwarded to matching read ports

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
i_raddr  in  NUM_RD*AW  read addresses, port k at [k*AW +: AW]
o_rdata  out  NUM_RD*DATA_WIDTH  read data, port k at [k*DATA_WIDTH +: DATA_WIDTH]
o_pending  out  NUM_RD  scoreboard bit of each read address
i_wen  in  NUM_WR  write enables
i_waddr  in  NUM_WR*AW  write addresses
i_wdata  in  NUM_WR*DATA_WIDTH  write data
i_rsv_en  in  1  reserve (set pending) request
i_rsv_addr  in  AW  register to reserve
o_ready  out  1  1 = clear done, array accepting traffic

Behaviour:
- State machine: CLEAR, READY. rst=1 at a posedge -> state=CLEAR, clr_ptr=0, all pending bits=0. rst has priority in every state; reset mid-clear restarts from 0.
- CLEAR: each cycle rf[clr_ptr]<=0, clr_ptr++; on clr_ptr==REG_FILE_SIZE-1 -> READY. o_ready=1 exactly REG_FILE_SIZE cycles after the first cycle with rst=0.
- While CLEAR or rst=1: o_ready=0, o_rdata=0, o_pending=0; writes and reservations ignored.
- READY writes: for each port w with i_wen[w]=1, rf[waddr_w]<=wdata_w at posedge and pending[waddr_w]<=0. Two ports same address: highest-index port wins. ZERO_REG=1 and waddr=0 -> dropped.
- Reservation: i_rsv_en=1 -> pending[i_rsv_addr]<=1 at posedge. Same cycle as a write to that address: reservation wins (pending=1, data still written). ZERO_REG=1 and addr 0 -> ignored.
- Reads combinational, zero-cycle: o_rdata_k = rf[raddr_k]. ZERO_REG=1 and raddr_k=0 -> 0.
- BYPASS=1: if any enabled, non-dropped write port matches raddr_k this cycle, o_rdata_k = that wdata (highest-index match), o_pending[k]=0 unless i_rsv_en targets the same address (pending still reports stored bit only; reservation visible next cycle). BYPASS=0: new data visible the cycle after the write.
- o_pending[k] = pending[raddr_k] (modified by bypass as above); 0 for reg 0 when ZERO_REG=1.
- Out-of-range addresses (>= REG_FILE_SIZE when not power of two): writes dropped, reads return 0.
- All storage and pending bits 0 after clear; no X on any output post-reset.

Test Plan:
- Reset/clear: preload rf via writes, pulse rst 1 cycle -> o_ready=0 for 32 cycles then 1; every read port returns 0 for all 32 addresses; reassert rst at clear cycle 10 -> o_ready rises 32 cycles after second release.
- Basic R/W: write reg5=0xDEADBEEF port0, reg9=0x12345678 port1 same cycle -> next cycle four read ports at 5,9,5,0 return 0xDEADBEEF,0x12345678,0xDEADBEEF,0.
- Write conflict + zero reg: both ports write reg3 (0x11, 0x22) -> reg3=0x22; write reg0=0xFFFF -> reads 0.
- Bypass: BYPASS=1, write reg7=0xA5A5A5A5 while port2 reads reg7 -> same-cycle o_rdata2=0xA5A5A5A5; BYPASS=0 build -> old value same cycle, new value next.
- Scoreboard: reserve reg12 -> next cycle o_pending=1 on port reading 12; write reg12 -> cleared next cycle (same cycle with BYPASS=1); reserve+write reg12 same cycle -> pending stays 1, data updated.
- Traffic during clear: writes/reserves issued while o_ready=0 -> no effect after clear completes; all regs 0, pending 0.

Source files
------------

// File: rtl/regfile_nrmw.sv
// Multi-port architectural register file with per-register pending scoreboard
// and a post-reset clear sequencer that zeroes every entry before accepting traffic.
module regfile_nrmw #(
  parameter int DATA_WIDTH    = 32,
  parameter int REG_FILE_SIZE = 32,
  parameter int NUM_RD        = 4,
  parameter int NUM_WR        = 2,
  parameter int ZERO_REG      = 1,
  parameter int BYPASS        = 1,
  localparam int AW = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_RD*AW-1:0]         i_raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] o_rdata,
  output logic [NUM_RD-1:0]            o_pending,
  input  logic [NUM_WR-1:0]            i_wen,
  input  logic [NUM_WR*AW-1:0]         i_waddr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] i_wdata,
  input  logic                         i_rsv_en,
  input  logic [AW-1:0]                i_rsv_addr,
  output logic                         o_ready
);

  typedef enum logic {CLEAR, READY} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] clr_ptr_reg, clr_ptr_next;
  logic          ready;

  logic [DATA_WIDTH-1:0] rf_reg [REG_FILE_SIZE];
  logic [REG_FILE_SIZE-1:0] pending_reg;

  logic [AW-1:0]         waddr_w [NUM_WR];
  logic [DATA_WIDTH-1:0] wdata_w [NUM_WR];
  logic [NUM_WR-1:0]     wr_ok;
  logic                  rsv_ok;

  // An address is usable when it exists and is not the hardwired zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < REG_FILE_SIZE) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  always_comb begin
    state_next   = state_reg;
    clr_ptr_next = clr_ptr_reg;
    case (state_reg)
      CLEAR: begin
        clr_ptr_next = clr_ptr_reg + AW'(1);
        if (clr_ptr_reg == AW'(REG_FILE_SIZE - 1))
          state_next = READY;
      end
      READY: ;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= CLEAR;
      clr_ptr_reg <= '0;
    end else begin
      state_reg   <= state_next;
      clr_ptr_reg <= clr_ptr_next;
    end
  end

  assign ready   = (state_reg == READY) && !rst;
  assign o_ready = ready;
  assign rsv_ok  = ready && i_rsv_en && addr_ok(i_rsv_addr);

  for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr
    assign waddr_w[gi] = i_waddr[gi*AW +: AW];
    assign wdata_w[gi] = i_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign wr_ok[gi]   = ready && i_wen[gi] && addr_ok(waddr_w[gi]);
  end

  // Later ports overwrite earlier ones; the reservation is applied last so it wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= '0;
    end else if (state_reg == CLEAR) begin
      rf_reg[clr_ptr_reg] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_ok[w]) begin
          rf_reg[waddr_w[w]]      <= wdata_w[w];
          pending_reg[waddr_w[w]] <= 1'b0;
        end
      end
      if (rsv_ok)
        pending_reg[i_rsv_addr] <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
    logic [AW-1:0]         raddr;
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp_data;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  pend;

    assign raddr = i_raddr[gi*AW +: AW];

    always_comb begin
      hit      = 1'b0;
      byp_data = '0;
      for (int w = 0; w < NUM_WR; w++) begin
        if ((BYPASS != 0) && wr_ok[w] && (waddr_w[w] == raddr)) begin
          hit      = 1'b1;
          byp_data = wdata_w[w];
        end
      end
      rdata = '0;
      pend  = 1'b0;
      if (ready && addr_ok(raddr)) begin
        if (hit) begin
          rdata = byp_data;
          // A same-cycle reservation only shows up next cycle, so report the stored bit.
          pend  = (rsv_ok && (i_rsv_addr == raddr)) ? pending_reg[raddr] : 1'b0;
        end else begin
          rdata = rf_reg[raddr];
          pend  = pending_reg[raddr];
        end
      end
    end

    assign o_rdata[gi*DATA_WIDTH +: DATA_WIDTH] = rdata;
    assign o_pending[gi]                        = pend;
  end

endmodule
